threshold_trigger: RTL and testbench
====================================

Name: threshold_trigger

Overview:
- Generates the single-cycle trigger pulse consumed by the triggered gate/toggle blocks in the pt_feedback chain.
- Monitors a signed ADC-rate data stream and fires on an upward threshold crossing, with hysteresis re-arming and a programmable holdoff.
- Also fires on a software trigger edge.
- Sits between the input filter chain and the trig_i inputs of downstream gates.

Parameters:
COUNTER_WIDTH, 18, width of holdoff counter and holdoff_cycles_i
DATA_WIDTH, 14, width of data_i, threshold_i, hysteresis_i
COUNT_WIDTH, 16, width of trig_count_o

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
enable_i  input  1  trigger engine enable; low forces IDLE
data_i  input  DATA_WIDTH  monitored sample, two's complement signed
threshold_i  input  DATA_WIDTH  firing level, signed
hysteresis_i  input  DATA_WIDTH  re-arm margin below threshold, unsigned
holdoff_cycles_i  input  COUNTER_WIDTH  dead time after each trigger, in clk cycles
sw_trig_i  input  1  software trigger, level; rising edge fires
trig_o  output  1  one-cycle trigger pulse
armed_o  output  1  high while state is ARMED
trig_count_o  output  COUNT_WIDTH  number of triggers fired, wrapping

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values: trig_o=0, armed_o=0, trig_count_o=0, state=IDLE, holdoff counter=0, sw_trig edge register=0.
- All outputs are registered.
- Arm level: rearm_lvl = sext(threshold_i) - zext(hysteresis_i), computed in DATA_WIDTH+1 signed bits. It never wraps; comparisons use the same extended width.
- Conditions:
  - fire_cond = data_i >= threshold_i (signed).
  - arm_cond = data_i < rearm_lvl.
- Software edge: sw_edge = sw_trig_i & ~sw_trig_q, where sw_trig_q is the registered sw_trig_i.
- States:
  - IDLE: entered whenever enable_i=0, from any state, on the next edge. trig_o forced 0. Counter cleared. trig_count_o held. When enable_i=1, go to WAIT_BELOW.
  - WAIT_BELOW: if arm_cond, go to ARMED. A signal already above threshold at enable never fires until it first drops below rearm_lvl.
  - ARMED: if fire_cond, fire.
  - HOLDOFF: counter counts 1..H (H latched from holdoff_cycles_i at fire). State is HOLDOFF for exactly H cycles after the fire cycle, then WAIT_BELOW. If H=0, go to WAIT_BELOW on the edge after fire.
- Fire: on the edge where the condition is sampled, trig_o <= 1 (high for exactly one cycle), trig_count_o increments (wraps all-ones to 0), state goes to HOLDOFF.
- Latency: sample at edge k satisfies the condition → trig_o high between edges k and k+1.
- sw_edge fires from WAIT_BELOW or ARMED, with the same pulse, count and holdoff behaviour. It is ignored in HOLDOFF and IDLE; those edges are not queued.
- sw_edge coinciding with fire_cond in ARMED produces one pulse and one count increment.
- A sw_trig_i held high produces only one edge.
- enable_i falling during HOLDOFF or a pulse cycle: the next edge goes to IDLE and trig_o=0. An in-progress pulse already high completes its single cycle, never extends.
- holdoff_cycles_i changes during HOLDOFF have no effect on the current holdoff.
- threshold_i/hysteresis_i changes take effect on the next sample.
- Hysteresis larger than the range is fine: rearm_lvl below the minimum sample means the block never re-arms, so no trigger except software.
- Asynchronous reset mid-pulse: trig_o drops immediately.

Test Plan:
- Reset/enable: rst_i pulse, enable_i=1, data_i=-100, threshold=500, hyst=50 → WAIT_BELOW then ARMED, armed_o=1 one cycle later, trig_o=0, count=0.
- Basic crossing: ramp data_i -100→+600 step 100, H=10 → single trig_o pulse the cycle after the first sample ≥500. count=1. armed_o=0 for 10 cycles, then no re-arm while data ≥450.
- Hysteresis chatter: data oscillating 480↔520 after first fire with H=0 → exactly one pulse. Drop to 449 → armed_o=1. Next 520 → second pulse, count=2.
- Software trigger: sw_trig_i held high 5 cycles in ARMED with data=0 → one pulse. sw edge during HOLDOFF (H=20) → no pulse. Simultaneous sw edge and crossing → one pulse, count +1.
- Enable at high level: data_i=+1000 constant, enable_i 0→1 → no trigger for 100 cycles. enable_i low mid-HOLDOFF → IDLE, trig_o=0, count held.
- Edge values: threshold=-8192, hyst=8191 (rearm_lvl=-16383, no wrap) → never arms. Count wrap: 65536 fires → trig_count_o returns to 0. Async rst_i asserted during trig_o high → all outputs 0 immediately.

Source files
------------

// File: rtl/threshold_trigger.sv
// -----------------------------------------------------------------------------
// threshold_trigger
//
// Produces a single-cycle trigger pulse for the downstream gate/toggle blocks.
// It fires when a signed sample stream crosses a threshold going upward. After
// a shot it waits for a programmable holdoff. It then re-arms only once the
// signal has dropped below (threshold - hysteresis). A rising edge on the
// software trigger input also fires.
//
// Ports:
//   clk_i            system clock
//   rst_i            asynchronous reset, active-high
//   enable_i         engine enable; low forces IDLE on the next edge
//   data_i           monitored sample, two's complement signed
//   threshold_i      firing level, signed
//   hysteresis_i     re-arm margin below threshold, unsigned
//   holdoff_cycles_i dead time after each trigger, in clk cycles
//   sw_trig_i        software trigger level; its rising edge fires
//   trig_o           one-cycle trigger pulse (registered)
//   armed_o          high while the engine is ARMED (registered)
//   trig_count_o     number of triggers fired, wrapping (registered)
// -----------------------------------------------------------------------------
module threshold_trigger #(
    parameter int COUNTER_WIDTH = 18,
    parameter int DATA_WIDTH    = 14,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [DATA_WIDTH-1:0]    threshold_i,
    input  logic [DATA_WIDTH-1:0]    hysteresis_i,
    input  logic [COUNTER_WIDTH-1:0] holdoff_cycles_i,
    input  logic                     sw_trig_i,
    output logic                     trig_o,
    output logic                     armed_o,
    output logic [COUNT_WIDTH-1:0]   trig_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BELOW,
        ARMED,
        HOLDOFF
    } state_t;

    state_t                     state;
    logic [COUNTER_WIDTH-1:0]   hold_cnt;
    logic [COUNTER_WIDTH-1:0]   hold_lim;
    logic                       sw_trig_q;

    // One extra bit lets threshold - hysteresis span the whole range without
    // wrapping. A huge hysteresis then puts the re-arm level below every
    // possible sample, so the engine never re-arms on data.
    logic signed [DATA_WIDTH:0] data_ext;
    logic signed [DATA_WIDTH:0] thr_ext;
    logic signed [DATA_WIDTH:0] rearm_lvl;

    logic fire_cond;
    logic arm_cond;
    logic sw_edge;
    logic fire_now;

    assign data_ext  = $signed({data_i[DATA_WIDTH-1], data_i});
    assign thr_ext   = $signed({threshold_i[DATA_WIDTH-1], threshold_i});
    assign rearm_lvl = thr_ext - $signed({1'b0, hysteresis_i});

    assign fire_cond = (data_ext >= thr_ext);
    assign arm_cond  = (data_ext < rearm_lvl);
    assign sw_edge   = sw_trig_i & ~sw_trig_q;

    // A software edge fires from either live state. A data crossing fires
    // only from ARMED. When both happen together they give one shot.
    assign fire_now = enable_i &&
                      (((state == WAIT_BELOW) && sw_edge) ||
                       ((state == ARMED) && (fire_cond || sw_edge)));

    // NOTE: every register here uses non-blocking assignment. That way all
    // state updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            hold_lim     <= '0;
            sw_trig_q    <= 1'b0;
            trig_o       <= 1'b0;
            armed_o      <= 1'b0;
            trig_count_o <= '0;
        end else begin
            // The edge detector always tracks the input. That way a level
            // that rose while idle or in holdoff is not seen later as a
            // fresh edge.
            sw_trig_q <= sw_trig_i;
            // Pulse and armed flag default low. Each is raised only on the
            // edge that makes it true, which keeps trig_o to one cycle.
            trig_o    <= 1'b0;
            armed_o   <= 1'b0;

            if (!enable_i) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else if (fire_now) begin
                trig_o       <= 1'b1;
                trig_count_o <= trig_count_o + COUNT_WIDTH'(1);
                hold_lim     <= holdoff_cycles_i;
                hold_cnt     <= '0;
                state        <= HOLDOFF;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_BELOW;
                    end
                    WAIT_BELOW: begin
                        if (arm_cond) begin
                            state   <= ARMED;
                            armed_o <= 1'b1;
                        end
                    end
                    ARMED: begin
                        armed_o <= 1'b1;
                    end
                    HOLDOFF: begin
                        // hold_cnt counts 1..H over the cycles after the
                        // fire cycle. The limit was latched at fire, so later
                        // changes to holdoff_cycles_i do not affect this
                        // holdoff.
                        if (hold_cnt == hold_lim) begin
                            state    <= WAIT_BELOW;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + COUNTER_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_threshold_trigger.sv
// -----------------------------------------------------------------------------
// tb_threshold_trigger
//
// Directed testbench for threshold_trigger. The main instance uses the default
// widths. A second instance with a 4-bit trigger counter exercises the
// count wrap-around in a short run. Inputs change 1 ns after the rising edge.
// Outputs are checked at that same point, so each check sees the result of the
// edge just taken.
// -----------------------------------------------------------------------------
module tb_threshold_trigger;

    localparam int CW = 18;
    localparam int DW = 14;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] data;
    logic [DW-1:0] threshold;
    logic [DW-1:0] hysteresis;
    logic [CW-1:0] holdoff;
    logic          sw_trig;
    logic          trig;
    logic          armed;
    logic [NW-1:0] count;

    logic          w_en;
    logic [DW-1:0] w_data;
    logic [DW-1:0] w_thr;
    logic [DW-1:0] w_hys;
    logic [CW-1:0] w_hold;
    logic          w_sw;
    logic          w_trig;
    logic          w_armed;
    logic [3:0]    w_count;

    int            errors = 0;
    int            checks = 0;
    logic [NW-1:0] exp_count;

    always #5 clk = ~clk;

    threshold_trigger #(.COUNTER_WIDTH(CW), .DATA_WIDTH(DW), .COUNT_WIDTH(NW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .data_i           (data),
        .threshold_i      (threshold),
        .hysteresis_i     (hysteresis),
        .holdoff_cycles_i (holdoff),
        .sw_trig_i        (sw_trig),
        .trig_o           (trig),
        .armed_o          (armed),
        .trig_count_o     (count)
    );

    threshold_trigger #(.COUNTER_WIDTH(CW), .DATA_WIDTH(DW), .COUNT_WIDTH(4)) u_wrap (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (w_en),
        .data_i           (w_data),
        .threshold_i      (w_thr),
        .hysteresis_i     (w_hys),
        .holdoff_cycles_i (w_hold),
        .sw_trig_i        (w_sw),
        .trig_o           (w_trig),
        .armed_o          (w_armed),
        .trig_count_o     (w_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (trig !== 1'b0 || armed !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: trig=%0b armed=%0b count=%0d, want 0 0 0", trig, armed, count);
        end
        rst    = 1'b0;
        enable = 1'b1;
        tick();  // IDLE -> WAIT_BELOW
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_below: armed=%0b want 0", armed);
        end
        tick();  // -100 < 450 -> ARMED
        checks++;
        if (armed !== 1'b1 || trig !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL reset_armed: armed=%0b trig=%0b count=%0d, want 1 0 0", armed, trig, count);
        end
    endtask

    task automatic test_crossing();
        for (int v = -100; v <= 600; v += 100) begin
            data = DW'(v);
            tick();
            if (v == 500) exp_count = exp_count + 16'd1;
            checks++;
            if (trig !== (v == 500)) begin
                errors++;
                $display("FAIL crossing_pulse data=%0d: trig=%0b want %0b", v, trig, (v == 500));
            end
        end
        checks++;
        if (count !== exp_count) begin
            errors++;
            $display("FAIL crossing_count: count=%0d want %0d", count, exp_count);
        end
        // Holdoff of 10, then WAIT_BELOW, which never arms while data stays >= 450.
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (armed !== 1'b0 || trig !== 1'b0) begin
                errors++;
                $display("FAIL crossing_no_rearm cycle %0d: armed=%0b trig=%0b want 0 0", i, armed, trig);
            end
        end
    endtask

    task automatic test_chatter();
        holdoff = '0;
        data    = DW'(450);  // equal to re-arm level: must not arm
        tick();
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL chatter_rearm_boundary: armed=%0b want 0", armed);
        end
        data = DW'(449);
        tick();
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL chatter_rearm_449: armed=%0b want 1", armed);
        end
        data = DW'(499);  // just below threshold: no fire
        tick();
        checks++;
        if (trig !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL chatter_below_thr: trig=%0b armed=%0b want 0 1", trig, armed);
        end
        data = DW'(520);
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("FAIL chatter_first_fire: trig=%0b count=%0d want 1 %0d", trig, count, exp_count);
        end
        for (int i = 0; i < 10; i++) begin
            data = (i % 2 == 0) ? DW'(480) : DW'(520);
            tick();
            checks++;
            if (trig !== 1'b0) begin
                errors++;
                $display("FAIL chatter_oscillate cycle %0d: trig=%0b want 0", i, trig);
            end
        end
        data = DW'(449);
        tick();
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL chatter_rearm_again: armed=%0b want 1", armed);
        end
        data = DW'(520);
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("FAIL chatter_second_fire: trig=%0b count=%0d want 1 %0d", trig, count, exp_count);
        end
    endtask

    task automatic test_sw_trigger();
        data = DW'(0);
        tick();  // HOLDOFF(H=0) -> WAIT_BELOW
        tick();  // -> ARMED
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL sw_armed_before: armed=%0b want 1", armed);
        end
        sw_trig = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (trig !== (i == 0)) begin
                errors++;
                $display("FAIL sw_held_high cycle %0d: trig=%0b want %0b", i, trig, (i == 0));
            end
        end
        exp_count = exp_count + 16'd1;
        checks++;
        if (count !== exp_count) begin
            errors++;
            $display("FAIL sw_held_count: count=%0d want %0d", count, exp_count);
        end
        // Edges inside a 20-cycle holdoff are dropped.
        holdoff = CW'(20);
        sw_trig = 1'b0;
        tick();
        sw_trig = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1) begin
            errors++;
            $display("FAIL sw_fire_h20: trig=%0b want 1", trig);
        end
        for (int i = 0; i < 3; i++) begin
            sw_trig = 1'b0;
            tick();
            sw_trig = 1'b1;
            tick();
            checks++;
            if (trig !== 1'b0) begin
                errors++;
                $display("FAIL sw_in_holdoff edge %0d: trig=%0b want 0", i, trig);
            end
        end
        sw_trig = 1'b0;
        repeat (20) tick();
        checks++;
        if (armed !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("FAIL sw_after_holdoff: armed=%0b count=%0d want 1 %0d", armed, count, exp_count);
        end
        // Software edge and data crossing on the same edge: one shot, one count.
        holdoff = CW'(3);
        data    = DW'(600);
        sw_trig = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("FAIL sw_coincident: trig=%0b count=%0d want 1 %0d", trig, count, exp_count);
        end
        // Changing holdoff now must not stretch the latched H=3.
        holdoff = CW'(50);
        data    = DW'(0);
        sw_trig = 1'b0;
        tick();
        checks++;
        if (trig !== 1'b0 || count !== exp_count) begin
            errors++;
            $display("FAIL sw_coincident_single: trig=%0b count=%0d want 0 %0d", trig, count, exp_count);
        end
        repeat (3) tick();  // HOLDOFF cycles 2,3 then WAIT_BELOW
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_latched_early: armed=%0b want 0", armed);
        end
        tick();
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL holdoff_latched_rearm: armed=%0b want 1", armed);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        tick();
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL enable_idle: armed=%0b want 0", armed);
        end
        holdoff = CW'(5);
        data    = DW'(1000);
        enable  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (trig !== 1'b0 || armed !== 1'b0) begin
                errors++;
                $display("FAIL enable_high_level cycle %0d: trig=%0b armed=%0b want 0 0", i, trig, armed);
            end
        end
        sw_trig = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("FAIL enable_sw_fire: trig=%0b count=%0d want 1 %0d", trig, count, exp_count);
        end
        sw_trig = 1'b0;
        tick();
        enable = 1'b0;  // drop mid-holdoff
        tick();
        checks++;
        if (trig !== 1'b0 || armed !== 1'b0 || count !== exp_count) begin
            errors++;
            $display("FAIL enable_off_holdoff: trig=%0b armed=%0b count=%0d want 0 0 %0d", trig, armed, count, exp_count);
        end
        enable = 1'b1;
        tick();
        sw_trig = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1) begin
            errors++;
            $display("FAIL enable_pulse_fire: trig=%0b want 1", trig);
        end
        enable = 1'b0;  // drop during the pulse cycle
        tick();
        checks++;
        if (trig !== 1'b0 || count !== exp_count) begin
            errors++;
            $display("FAIL enable_off_pulse: trig=%0b count=%0d want 0 %0d", trig, count, exp_count);
        end
        enable = 1'b1;
        data   = DW'(0);
        tick();
        tick();
        checks++;
        if (armed !== 1'b1 || trig !== 1'b0 || count !== exp_count) begin
            errors++;
            $display("FAIL enable_held_sw_no_edge: armed=%0b trig=%0b count=%0d want 1 0 %0d", armed, trig, count, exp_count);
        end
        sw_trig = 1'b0;
    endtask

    task automatic test_edge_values();
        threshold  = DW'(-8192);
        hysteresis = DW'(8191);  // re-arm level -16383
        data       = DW'(-8192);
        enable     = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (armed !== 1'b0 || trig !== 1'b0) begin
                errors++;
                $display("FAIL edge_never_arms cycle %0d: armed=%0b trig=%0b want 0 0", i, armed, trig);
            end
        end
        hysteresis = DW'(1);  // re-arm level -8193, still below every sample
        repeat (5) tick();
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL edge_min_hyst: armed=%0b want 0", armed);
        end
        threshold  = DW'(500);
        hysteresis = DW'(50);
    endtask

    task automatic test_async_reset();
        sw_trig = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (trig !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("FAIL async_pre_pulse: trig=%0b count=%0d want 1 %0d", trig, count, exp_count);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (trig !== 1'b0 || armed !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_mid_pulse: trig=%0b armed=%0b count=%0d want 0 0 0", trig, armed, count);
        end
        exp_count = '0;
        sw_trig   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_count_wrap();
        w_en = 1'b1;
        tick();  // IDLE -> WAIT_BELOW
        for (int f = 1; f <= 16; f++) begin
            w_sw = 1'b1;
            tick();
            checks++;
            if (w_trig !== 1'b1) begin
                errors++;
                $display("FAIL wrap_fire %0d: trig=%0b want 1", f, w_trig);
            end
            if (f == 15) begin
                checks++;
                if (w_count !== 4'd15) begin
                    errors++;
                    $display("FAIL wrap_all_ones: count=%0d want 15", w_count);
                end
            end
            w_sw = 1'b0;
            tick();
        end
        checks++;
        if (w_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_to_zero: count=%0d want 0", w_count);
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        data       = DW'(-100);
        threshold  = DW'(500);
        hysteresis = DW'(50);
        holdoff    = CW'(10);
        sw_trig    = 1'b0;
        w_en       = 1'b0;
        w_data     = DW'(0);
        w_thr      = DW'(500);
        w_hys      = DW'(50);
        w_hold     = '0;
        w_sw       = 1'b0;
        exp_count  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_crossing();
        test_chatter();
        test_sw_trigger();
        test_enable();
        test_edge_values();
        test_async_reset();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
